// File: rtl/mem_port_scheduler.sv
// Registered, starvation-safe owner of the single memory4c port (I-fill, D-fill, write-through).
// Grants land one cycle after the IDLE decision; losers hold req until IDLE, no preemption.
module mem_port_scheduler #(
  parameter int BURST_LEN    = 8,
  parameter int STARVE_LIMIT = 2,
  parameter int AW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] wr_data,
  input  logic          mem_data_valid,
  output logic          grant_i,
  output logic          grant_d,
  output logic          wr_ack,
  output logic          mem_enable,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  output logic          i_data_valid,
  output logic          d_data_valid,
  output logic          protocol_err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    BURST_CNT  = 4'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    WRITE
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt, starve_inc;
  logic [3:0]    beat_cnt, beat_nxt, beat_sum;
  logic          err_nxt;
  logic          own_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      beat_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      starve_cnt   <= starve_nxt;
      beat_cnt     <= beat_nxt;
      protocol_err <= err_nxt;
    end
  end

  // beat_sum includes a beat arriving in the release cycle, so the burst check sees it too.
  always_comb begin
    own_req    = (state == GNT_I) ? i_req : d_req;
    beat_sum   = (mem_data_valid && beat_cnt != 4'hF) ? beat_cnt + 4'd1 : beat_cnt;
    starve_inc = !i_req ? '0 :
                 (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    beat_nxt   = beat_cnt;
    err_nxt    = protocol_err;
    case (state)
      IDLE: begin
        beat_nxt = '0;
        if (i_req && starve_cnt == STARVE_MAX) begin
          state_nxt  = GNT_I;
          starve_nxt = '0;
        end else if (wr_req) begin
          state_nxt  = WRITE;
          starve_nxt = starve_inc;
        end else if (d_req) begin
          state_nxt  = GNT_D;
          starve_nxt = starve_inc;
        end else if (i_req) begin
          state_nxt  = GNT_I;
          starve_nxt = '0;
        end else begin
          starve_nxt = '0;
        end
      end
      GNT_I, GNT_D: begin
        beat_nxt = beat_sum;
        if (!own_req) begin
          state_nxt = IDLE;
          if (beat_sum != BURST_CNT) err_nxt = 1'b1;
        end
      end
      WRITE: state_nxt = IDLE;
    endcase
  end

  // Port mux decodes straight from the state flop so an async reset drops it immediately.
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    wr_ack     = 1'b0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: ;
      GNT_I: begin
        grant_i    = 1'b1;
        mem_enable = 1'b1;
        mem_addr   = i_addr;
      end
      GNT_D: begin
        grant_d    = 1'b1;
        mem_enable = 1'b1;
        mem_addr   = d_addr;
      end
      WRITE: begin
        wr_ack     = 1'b1;
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = wr_addr;
        mem_wdata  = wr_data;
      end
    endcase
    i_data_valid = mem_data_valid && grant_i;
    d_data_valid = mem_data_valid && grant_d;
  end

endmodule
